flash_conv_ctrl: RTL and testbench



---
 rtl/adc_pkg.sv | 29 ++
 rtl/therm_bubble_enc.sv | 28 ++
 rtl/flash_conv_ctrl.sv | 156 +++++++++++++++
 tb/tb_flash_conv_ctrl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// Shared types and helpers for the flash ADC conversion path:
// word widths, sequencer states and majority/popcount functions.
package adc_pkg;

  localparam int THERM_W = 15;
  localparam int CODE_W  = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SAMPLE = 3'd1,
    LATCH  = 3'd2,
    ACCUM  = 3'd3,
    OUTPUT = 3'd4
  } state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic [CODE_W-1:0] popcount15(input logic [THERM_W-1:0] w);
    logic [CODE_W-1:0] n;
    n = 4'd0;
    for (int i = 0; i < THERM_W; i++) begin
      n = n + {3'd0, w[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/therm_bubble_enc.sv
// Single-pass bubble correction of a thermometer word followed by popcount.
// Purely combinational; also usable by the standalone encoder path.
module therm_bubble_enc
  import adc_pkg::*;
(
  input  logic [THERM_W-1:0] y,
  output logic [CODE_W-1:0]  value,
  output logic               changed
);

  logic [THERM_W+1:0] ext_s;
  logic [THERM_W-1:0] corr_s;

  // Pad with the virtual neighbours: a one above the MSB, a zero below the LSB.
  assign ext_s = {1'b1, y, 1'b0};

  // Each bit becomes the majority of itself and its raw neighbours.
  always_comb begin
    corr_s = '0;
    for (int i = 0; i < THERM_W; i++) begin
      corr_s[i] = maj3(ext_s[i+2], ext_s[i+1], ext_s[i]);
    end
  end

  assign value   = popcount15(corr_s);
  assign changed = (corr_s != y);

endmodule

// File: rtl/flash_conv_ctrl.sv
// Flash ADC conversion sequencer: sample/latch timing, capture, averaging
// and a valid/ready output register.
module flash_conv_ctrl
  import adc_pkg::*;
#(
  parameter int SAMPLE_CYC = 2,
  parameter int LATCH_CYC  = 1,
  parameter int AVG_LOG2   = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               cont,
  input  logic [THERM_W-1:0] Y,
  output logic               samp_en,
  output logic               latch_en,
  output logic               busy,
  output logic [CODE_W-1:0]  code,
  output logic               code_valid,
  input  logic               code_ready,
  output logic               bubble_err
);

  localparam int ACC_W = CODE_W + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0] N_CONV    = CNT_W'(1 << AVG_LOG2);
  localparam logic [3:0]       SAMP_LAST = 4'(SAMPLE_CYC - 1);
  localparam logic [3:0]       LAT_LAST  = 4'(LATCH_CYC - 1);

  state_t             state_r;
  state_t             next_state_s;
  logic [3:0]         phase_r;
  logic [CNT_W-1:0]   smp_cnt_r;
  logic [CNT_W-1:0]   smp_next_s;
  logic [ACC_W-1:0]   acc_r;
  logic               err_acc_r;
  logic [THERM_W-1:0] y_r;
  logic [CODE_W-1:0]  enc_value_s;
  logic               enc_changed_s;
  logic               out_free_s;
  logic               load_s;

  therm_bubble_enc u_enc (
    .y       (y_r),
    .value   (enc_value_s),
    .changed (enc_changed_s)
  );

  assign smp_next_s = smp_cnt_r + CNT_W'(1);
  assign out_free_s = ~code_valid | code_ready;

  // Next-state decode; a result loads only when the output register is free.
  always_comb begin
    next_state_s = state_r;
    load_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) next_state_s = SAMPLE;
        else       next_state_s = IDLE;
      end
      SAMPLE: begin
        if (phase_r == SAMP_LAST) next_state_s = LATCH;
        else                      next_state_s = SAMPLE;
      end
      LATCH: begin
        if (phase_r == LAT_LAST) next_state_s = ACCUM;
        else                     next_state_s = LATCH;
      end
      ACCUM: begin
        if (smp_next_s == N_CONV) next_state_s = OUTPUT;
        else                      next_state_s = SAMPLE;
      end
      OUTPUT: begin
        if (out_free_s) begin
          load_s       = 1'b1;
          next_state_s = cont ? SAMPLE : IDLE;
        end else begin
          next_state_s = OUTPUT;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_r <= IDLE;
    else      state_r <= next_state_s;
  end

  // Phase counter: cycles spent in the current SAMPLE or LATCH phase.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_r <= 4'd0;
    end else if ((state_r == SAMPLE || state_r == LATCH) && next_state_s == state_r) begin
      phase_r <= phase_r + 4'd1;
    end else begin
      phase_r <= 4'd0;
    end
  end

  // Capture the comparator word on the edge that leaves LATCH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      y_r <= '0;
    end else if (state_r == LATCH && next_state_s == ACCUM) begin
      y_r <= Y;
    end
  end

  // Accumulate corrected conversions; cleared when the result is handed off.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_r     <= '0;
      err_acc_r <= 1'b0;
      smp_cnt_r <= '0;
    end else if (state_r == ACCUM) begin
      acc_r     <= acc_r + ACC_W'(enc_value_s);
      err_acc_r <= err_acc_r | enc_changed_s;
      smp_cnt_r <= smp_next_s;
    end else if (load_s) begin
      acc_r     <= '0;
      err_acc_r <= 1'b0;
      smp_cnt_r <= '0;
    end
  end

  // Output register with valid/ready; a load in the accept cycle keeps valid high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      code       <= '0;
      bubble_err <= 1'b0;
      code_valid <= 1'b0;
    end else if (load_s) begin
      code       <= acc_r[ACC_W-1:AVG_LOG2];
      bubble_err <= err_acc_r;
      code_valid <= 1'b1;
    end else if (code_valid && code_ready) begin
      code_valid <= 1'b0;
    end
  end

  // Comparator strobes and busy, registered from the upcoming state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      samp_en  <= 1'b0;
      latch_en <= 1'b0;
      busy     <= 1'b0;
    end else begin
      samp_en  <= (next_state_s == SAMPLE);
      latch_en <= (next_state_s == LATCH);
      busy     <= (next_state_s != IDLE);
    end
  end

endmodule

// File: tb/tb_flash_conv_ctrl.sv
// Self-checking bench: two instances (no averaging / pairs averaged) checked
// every cycle against a schedule-based reference model, plus directed literals.
module tb_flash_conv_ctrl;

  localparam int S = 2;
  localparam int L = 1;
  localparam int PER = S + L + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start [2];
  logic        cont  [2];
  logic        rdy   [2];
  logic [14:0] yv    [2];
  logic        samp  [2];
  logic        lat   [2];
  logic        bsy   [2];
  logic        cv    [2];
  logic        berr  [2];
  logic [3:0]  code  [2];

  int checks = 0;
  int errors = 0;

  // reference model state, per instance
  int          m_active [2];
  int          m_t      [2];
  int          m_acc    [2];
  int          m_err    [2];
  int          m_ov     [2];
  int          m_code   [2];
  int          m_berr   [2];
  logic [14:0] m_ycap   [2];

  always #5 clk = ~clk;

  flash_conv_ctrl #(.SAMPLE_CYC(S), .LATCH_CYC(L), .AVG_LOG2(0)) dut0 (
    .clk(clk), .rst(rst), .start(start[0]), .cont(cont[0]), .Y(yv[0]),
    .samp_en(samp[0]), .latch_en(lat[0]), .busy(bsy[0]), .code(code[0]),
    .code_valid(cv[0]), .code_ready(rdy[0]), .bubble_err(berr[0]));

  flash_conv_ctrl #(.SAMPLE_CYC(S), .LATCH_CYC(L), .AVG_LOG2(1)) dut1 (
    .clk(clk), .rst(rst), .start(start[1]), .cont(cont[1]), .Y(yv[1]),
    .samp_en(samp[1]), .latch_en(lat[1]), .busy(bsy[1]), .code(code[1]),
    .code_valid(cv[1]), .code_ready(rdy[1]), .bubble_err(berr[1]));

  function automatic int nconv(input int k);
    return (k == 0) ? 1 : 2;
  endfunction

  function automatic int corr_count(input logic [14:0] w);
    int e[17];
    int n = 0;
    e[0] = 0;
    e[16] = 1;
    for (int i = 0; i < 15; i++) e[i+1] = int'(w[i]);
    for (int i = 1; i <= 15; i++) if (e[i-1] + e[i] + e[i+1] >= 2) n++;
    return n;
  endfunction

  function automatic int corr_changed(input logic [14:0] w);
    int e[17];
    int c = 0;
    e[0] = 0;
    e[16] = 1;
    for (int i = 0; i < 15; i++) e[i+1] = int'(w[i]);
    for (int i = 1; i <= 15; i++) if (((e[i-1] + e[i] + e[i+1]) >= 2 ? 1 : 0) != e[i]) c = 1;
    return c;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset(input int k);
    m_active[k] = 0; m_t[k] = 0; m_acc[k] = 0; m_err[k] = 0;
    m_ov[k] = 0; m_code[k] = 0; m_berr[k] = 0; m_ycap[k] = '0;
  endtask

  task automatic model_step(input int k);
    int  w;
    int  p;
    bit  free;
    bit  load;
    w    = nconv(k) * PER;
    free = (m_ov[k] == 0) || rdy[k];
    load = 0;
    if (m_active[k] == 0) begin
      if (start[k]) begin m_active[k] = 1; m_t[k] = 0; end
    end else if (m_t[k] < w) begin
      p = m_t[k] % PER;
      if (p == S + L - 1) m_ycap[k] = yv[k];
      if (p == S + L) begin
        m_acc[k] += corr_count(m_ycap[k]);
        if (corr_changed(m_ycap[k]) != 0) m_err[k] = 1;
      end
      m_t[k]++;
    end else if (free) begin
      load      = 1;
      m_code[k] = m_acc[k] / nconv(k);
      m_berr[k] = m_err[k];
      m_acc[k]  = 0;
      m_err[k]  = 0;
      if (cont[k]) m_t[k] = 0;
      else         m_active[k] = 0;
    end
    if (load)                   m_ov[k] = 1;
    else if (m_ov[k] != 0 && rdy[k]) m_ov[k] = 0;
  endtask

  initial begin
    model_reset(0);
    model_reset(1);
    forever begin
      @(posedge clk or negedge rst);
      for (int k = 0; k < 2; k++) begin
        if (!rst) model_reset(k);
        else      model_step(k);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        for (int k = 0; k < 2; k++) begin
          int w;
          int p;
          int in_conv;
          w = nconv(k) * PER;
          p = m_t[k] % PER;
          in_conv = (m_active[k] != 0 && m_t[k] < w) ? 1 : 0;
          chk($sformatf("samp_en%0d", k), int'(samp[k]), (in_conv != 0 && p < S) ? 1 : 0);
          chk($sformatf("latch_en%0d", k), int'(lat[k]), (in_conv != 0 && p >= S && p < S + L) ? 1 : 0);
          chk($sformatf("busy%0d", k), int'(bsy[k]), m_active[k]);
          chk($sformatf("code_valid%0d", k), int'(cv[k]), m_ov[k]);
          if (m_ov[k] != 0) begin
            chk($sformatf("code%0d", k), int'(code[k]), m_code[k]);
            chk($sformatf("bubble_err%0d", k), int'(berr[k]), m_berr[k]);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic conv0(input logic [14:0] y, input int exp_code, input int exp_err, input string nm);
    int n;
    yv[0] = y;
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    n = 0;
    while (cv[0] !== 1'b1 && n < 30) begin tick(); n++; end
    chk({nm, "_timeout"}, (n < 30) ? 1 : 0, 1);
    chk({nm, "_code"}, int'(code[0]), exp_code);
    chk({nm, "_berr"}, int'(berr[0]), exp_err);
    tick();
    tick();
  endtask

  initial begin
    logic [14:0] w;
    int          idx;
    for (int k = 0; k < 2; k++) begin
      start[k] = 1'b0; cont[k] = 1'b0; rdy[k] = 1'b1; yv[k] = '0;
    end
    repeat (3) tick();
    chk("reset_valid", int'(cv[0]), 0);
    chk("reset_busy", int'(bsy[0]), 0);
    rst = 1'b1;
    tick();

    // first conversion on both instances, start high in cycle 0
    yv[0] = 15'h7fff;
    for (int c = 0; c <= 12; c++) begin
      start[0] = (c == 0);
      start[1] = (c == 0);
      yv[1] = (c <= 4) ? 15'h7ff8 : 15'h7ff0;
      @(negedge clk);
      if (c == 1 || c == 2) chk("lit_samp", int'(samp[0]), 1);
      if (c == 3) begin chk("lit_latch", int'(lat[0]), 1); chk("lit_samp3", int'(samp[0]), 0); end
      if (c == 5) chk("lit_valid5", int'(cv[0]), 0);
      if (c == 6) begin
        chk("lit_valid6", int'(cv[0]), 1);
        chk("lit_code15", int'(code[0]), 15);
        chk("lit_berr0", int'(berr[0]), 0);
        chk("lit_busy6", int'(bsy[0]), 0);
      end
      if (c == 9) chk("lit_avg_valid9", int'(cv[1]), 0);
      if (c == 10) begin
        chk("lit_avg_valid10", int'(cv[1]), 1);
        chk("lit_avg_code11", int'(code[1]), 11);
      end
      @(posedge clk);
      #1;
    end

    // thermometer sweep 14 down to 0, then a bubbled word
    for (int k = 14; k >= 0; k--) begin
      w = 15'h7fff;
      w = w << (15 - k);
      conv0(w, k, 0, $sformatf("sweep%0d", k));
    end
    conv0(15'b111111110100000, 9, 1, "bubble");

    // continuous mode with a 20-cycle stall on the output
    cont[0] = 1'b1;
    rdy[0]  = 1'b0;
    for (int c = 0; c <= 29; c++) begin
      start[0] = (c == 0);
      yv[0] = (c <= 4) ? 15'h7f00 : 15'h7ffc;
      if (c == 26) begin rdy[0] = 1'b1; cont[0] = 1'b0; end
      @(negedge clk);
      if (c >= 10 && c <= 25) begin
        chk("stall_samp", int'(samp[0]), 0);
        chk("stall_valid", int'(cv[0]), 1);
        chk("stall_code7", int'(code[0]), 7);
      end
      if (c == 27) begin chk("b2b_valid", int'(cv[0]), 1); chk("b2b_code13", int'(code[0]), 13); end
      if (c == 28) begin chk("b2b_drop", int'(cv[0]), 0); chk("b2b_idle", int'(bsy[0]), 0); end
      @(posedge clk);
      #1;
    end

    // asynchronous reset in the middle of LATCH while a code is pending
    cont[0] = 1'b1;
    rdy[0]  = 1'b0;
    yv[0]   = 15'h7fe0;
    for (int c = 0; c < 8; c++) begin
      start[0] = (c == 0);
      tick();
    end
    #2;
    chk("pre_rst_latch", int'(lat[0]), 1);
    chk("pre_rst_valid", int'(cv[0]), 1);
    rst = 1'b0;
    #1;
    chk("rst_samp", int'(samp[0]), 0);
    chk("rst_latch", int'(lat[0]), 0);
    chk("rst_busy", int'(bsy[0]), 0);
    chk("rst_valid", int'(cv[0]), 0);
    chk("rst_code", int'(code[0]), 0);
    chk("rst_berr", int'(berr[0]), 0);
    @(negedge clk);
    rst = 1'b1;
    cont[0] = 1'b0;
    rdy[0]  = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 0; c <= 7; c++) begin
      start[0] = (c == 0);
      @(negedge clk);
      if (c == 5) chk("post_rst_valid5", int'(cv[0]), 0);
      if (c == 6) begin chk("post_rst_valid6", int'(cv[0]), 1); chk("post_rst_code10", int'(code[0]), 10); end
      @(posedge clk);
      #1;
    end

    // randomized traffic on both instances against the model
    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < 2; k++) begin
        start[k] = ($urandom_range(0, 3) == 0);
        cont[k]  = ($urandom_range(0, 2) == 0);
        rdy[k]   = ($urandom_range(0, 2) != 0);
        w = 15'h7fff;
        w = w << (15 - $urandom_range(0, 15));
        if ($urandom_range(0, 3) == 0) begin
          idx = $urandom_range(0, 14);
          w[idx] = ~w[idx];
        end
        yv[k] = w;
      end
      tick();
    end

    for (int k = 0; k < 2; k++) begin
      start[k] = 1'b0; cont[k] = 1'b0; rdy[k] = 1'b1;
    end
    repeat (20) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
